// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package md_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_XLEN);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Divide ops have the upper encoding bit set
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  // Signed ops have the lower encoding bit clear
  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_step_unit.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply accumulator layout: {partial product high, remaining multiplier bits}.
// Divide accumulator layout:   {partial remainder, dividend bits / quotient bits}.
module md_step_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc_c
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  // Single step: add-then-shift-right for multiply, shift-then-trial-subtract for divide
  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    if (i_is_div) begin
      if (w_diff[XLEN]) begin
        o_acc_c = {i_acc[2*XLEN-2:0], 1'b0};
      end else begin
        o_acc_c = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      o_acc_c = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_hilo_sequencer.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Optional MD_HILO_BYPASS_EN: forwards mthi/mtlo data and the FIX-cycle result
// onto hi/lo combinationally, and lets mfhi/mflo proceed during FIX.
module md_hilo_sequencer
  import md_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            mfhi,
  input  logic            mflo,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            md_busy,
  output logic            md_done,
  output logic            stall
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  md_state_e         r_state, w_state_nxt;
  md_op_e            r_op, w_op_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic [XLEN-1:0]   r_hi, w_hi_nxt;
  logic [XLEN-1:0]   r_lo, w_lo_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  md_op_e            w_in_op;
  logic              w_in_div;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  logic [XLEN-1:0]   w_res_hi, w_res_lo;

  md_step_unit #(.XLEN(XLEN)) u_step (
    .i_is_div (md_is_div(r_op)),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc_c  (w_step_acc)
  );

  // Operand magnitudes and sign flags for the op being issued
  always_comb begin
    w_in_op  = md_op_e'(md_op);
    w_in_div = md_is_div(w_in_op);
    w_a_neg  = md_is_signed(w_in_op) & operand_a[XLEN-1];
    w_b_neg  = md_is_signed(w_in_op) & operand_b[XLEN-1];
    w_a_mag  = w_a_neg ? (~operand_a + XLEN'(1)) : operand_a;
    w_b_mag  = w_b_neg ? (~operand_b + XLEN'(1)) : operand_b;
  end

  // Sign-corrected final result from the accumulator
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + (2*XLEN)'(1)) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
    if (md_is_div(r_op)) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end else begin
      w_res_hi = w_prod[2*XLEN-1:XLEN];
      w_res_lo = w_prod[XLEN-1:0];
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_opnd_nxt  = r_opnd;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (mthi) w_hi_nxt = wdata;
        if (mtlo) w_lo_nxt = wdata;
        if (md_start) begin
          w_op_nxt  = w_in_op;
          w_cnt_nxt = '0;
          if (w_in_div && (operand_b == '0)) begin
            // Divide by zero skips iteration: hi=dividend, lo=all ones
            w_acc_nxt   = {operand_a, {XLEN{1'b1}}};
            w_neg_q_nxt = 1'b0;
            w_neg_r_nxt = 1'b0;
            w_state_nxt = FIX;
          end else begin
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
            if (w_in_div) begin
              w_acc_nxt  = {{XLEN{1'b0}}, w_a_mag};
              w_opnd_nxt = w_b_mag;
            end else begin
              w_acc_nxt  = {{XLEN{1'b0}}, w_b_mag};
              w_opnd_nxt = w_a_mag;
            end
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_acc_nxt = w_step_acc;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = FIX;
      end
      FIX: begin
        w_hi_nxt    = w_res_hi;
        w_lo_nxt    = w_res_lo;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= MD_MULT;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_opnd  <= w_opnd_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign md_busy = r_busy;
  assign md_done = r_done;

`ifdef MD_HILO_BYPASS_EN
  // Forward pending writes and the completing result onto hi/lo
  always_comb begin
    hi = r_hi;
    lo = r_lo;
    if (r_state == IDLE) begin
      if (mthi) hi = wdata;
      if (mtlo) lo = wdata;
    end else if (r_state == FIX) begin
      hi = w_res_hi;
      lo = w_res_lo;
    end
  end

  assign stall = md_busy & ((~(r_state == FIX) & (mfhi | mflo)) | mthi | mtlo | md_start);
`else
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = md_busy & (mfhi | mflo | mthi | mtlo | md_start);
`endif

endmodule

// File: tb/tb_md_hilo_sequencer.sv
// Scoreboard bench for md_hilo_sequencer (default build, bypass disabled).
module tb_md_hilo_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        mfhi = 1'b0;
  logic        mflo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        md_busy, md_done, stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  md_hilo_sequencer dut (
    .clock(clock), .reset(reset), .md_start(md_start), .md_op(md_op),
    .operand_a(operand_a), .operand_b(operand_b), .mthi(mthi), .mtlo(mtlo),
    .mfhi(mfhi), .mflo(mflo), .wdata(wdata), .hi(hi), .lo(lo),
    .md_busy(md_busy), .md_done(md_done), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every md_done pops the next expected {hi,lo}
  always @(negedge clock) begin : monitor
    logic [63:0] e;
    if (reset && md_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_md_done: got hi=0x%0h lo=0x%0h expected no completion", hi, lo);
      end else begin
        e = exp_q.pop_front();
        chk("md_result", {hi, lo}, e);
      end
    end
  end

  // Count busy cycles from the current negedge, then check the done pulse
  task automatic wait_done(input string name, input int exp_busy);
    int n;
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({name, "_done_pulse"}, {63'd0, md_done}, 64'd1);
    @(negedge clock);
    chk({name, "_done_clear"}, {63'd0, md_done}, 64'd0);
  endtask

  task automatic run_md(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int exp_busy);
    @(negedge clock);
    md_start  = 1'b1;
    md_op     = op;
    operand_a = a;
    operand_b = b;
    exp_q.push_back({eh, el});
    @(negedge clock);
    md_start = 1'b0;
    wait_done(name, exp_busy);
  endtask

  initial begin
    // Reset state, with a request asserted to confirm stall stays low
    mfhi = 1'b1;
    md_start = 1'b1;
    #2;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_done", {63'd0, md_done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    mfhi = 1'b0;
    md_start = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // mthi+mtlo together, then mtlo alone
    @(negedge clock);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both", {hi, lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});
    mtlo = 1'b1; wdata = 32'h0000_0077;
    @(negedge clock);
    mtlo = 1'b0;
    chk("mtlo_only", {hi, lo}, {32'hA5A5_5A5A, 32'h0000_0077});

    // mthi alongside md_start: write lands now, mult result later overwrites
    md_start = 1'b1; md_op = 2'b00; operand_a = 32'd7; operand_b = 32'hFFFF_FFFD;
    mthi = 1'b1; wdata = 32'h0000_CAFE;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(negedge clock);
    md_start = 1'b0; mthi = 1'b0;
    chk("mt_with_start", {32'd0, hi}, {32'd0, 32'h0000_CAFE});
    wait_done("mult_neg", 33);

    run_md("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_md("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_md("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_md("divu",      2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33);
    run_md("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_md("div_zero",  2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1);
    run_md("divu_zero", 2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1);

    // mfhi and mthi held from cycle 3 of a multu: stall until idle, then mthi applies
    @(negedge clock);
    md_start = 1'b1; md_op = 2'b01; operand_a = 32'd3; operand_b = 32'd5;
    exp_q.push_back({32'd0, 32'd15});
    @(negedge clock);
    md_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    mfhi = 1'b1; mthi = 1'b1; wdata = 32'h0000_1234;
    begin
      int n;
      n = 0;
      #1;
      while (md_busy && n < 100) begin
        chk("stall_busy", {63'd0, stall}, 64'd1);
        n++;
        @(negedge clock);
        #1;
      end
      chk("stall_cycles", 64'(n), 64'd31);
      chk("stall_idle", {63'd0, stall}, 64'd0);
    end
    @(negedge clock);
    mfhi = 1'b0; mthi = 1'b0;
    chk("mthi_after_busy", {hi, lo}, {32'h0000_1234, 32'd15});

    // Reset during CALC at counter 10: immediate clear, no completion
    md_start = 1'b1; md_op = 2'b00; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clock);
    md_start = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_abort_busy", {63'd0, md_busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", {63'd0, md_busy}, 64'd0);
    chk("abort_done", {63'd0, md_done}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_abort_busy", {63'd0, md_busy}, 64'd0);

    run_md("mult_after_rst", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33);

    repeat (2) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
